// File: rtl/seq_divider_8by4.sv
// Sequential restoring unsigned divider, one quotient bit per clock, Start/Busy/Done handshake.
// Define DIV_SELFCHECK_EN to build the Quotient*Divisor+Remainder result checker driving CheckErr.
module seq_divider_8by4 #(
  parameter int unsigned DIVIDEND_W = 8,
  parameter int unsigned DIVISOR_W  = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic [DIVIDEND_W-1:0] Dividend,
  input  logic [DIVISOR_W-1:0]  Divisor,
  output logic                  Busy,
  output logic                  Done,
  output logic [DIVIDEND_W-1:0] Quotient,
  output logic [DIVISOR_W-1:0]  Remainder,
  output logic                  DivByZero,
  output logic                  CheckErr
);

  localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  rem;
  logic [DIVISOR_W:0]    p_shift;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_next;
  logic [DIVIDEND_W-1:0] quo_next;
  logic                  accept;
  logic                  last;

  // One restoring step: dvd shifts its MSB into the partial remainder and collects quotient bits at the LSB.
  assign p_shift  = {rem, dvd[DIVIDEND_W-1]};
  assign ge       = (p_shift >= {1'b0, dvs});
  assign rem_next = ge ? DIVISOR_W'(p_shift - {1'b0, dvs}) : p_shift[DIVISOR_W-1:0];
  assign quo_next = {dvd[DIVIDEND_W-2:0], ge};
  assign accept   = Start && ((state == IDLE) || (state == DONE));
  assign last     = (state == RUN) && (cnt == CNT_W'(DIVIDEND_W - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            if (Divisor == '0) begin
              state     <= DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= '0;
              DivByZero <= 1'b1;
            end else begin
              state     <= RUN;
              Busy      <= 1'b1;
              dvd       <= Dividend;
              dvs       <= Divisor;
              rem       <= '0;
              cnt       <= '0;
              DivByZero <= 1'b0;
            end
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          dvd <= quo_next;
          rem <= rem_next;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            state     <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= quo_next;
            Remainder <= rem_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_SELFCHECK_EN
  localparam int unsigned PROD_W = DIVIDEND_W + DIVISOR_W;

  logic [DIVIDEND_W-1:0] dvd_orig;
  logic                  chk_bad;

  // Rebuild the dividend from the final result; flag lands in the DONE cycle alongside the results.
  assign chk_bad = ((PROD_W'(quo_next) * PROD_W'(dvs)) + PROD_W'(rem_next)) != PROD_W'(dvd_orig);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dvd_orig <= '0;
      CheckErr <= 1'b0;
    end else begin
      if (accept) dvd_orig <= Dividend;
      CheckErr <= last && chk_bad;
    end
  end
`else
  assign CheckErr = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Scoreboard bench for seq_divider_8by4: directed cases, Start-during-RUN, mid-run reset, full operand sweep.
module tb_seq_divider_8by4;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Dividend = '0;
  logic [3:0] Divisor = '0;
  logic       Busy;
  logic       Done;
  logic [7:0] Quotient;
  logic [3:0] Remainder;
  logic       DivByZero;
  logic       CheckErr;

  seq_divider_8by4 dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .DivByZero (DivByZero),
    .CheckErr  (CheckErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge inside the Done cycle.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit glitch);
    exp_t  e;
    exp_t  got;
    int    cyc;
    int    busy_n;
    bit    seen;
    string id;
    id    = $sformatf("%0d/%0d", a, b);
    e.q   = (b == 4'd0) ? 8'hFF : 8'(a / {4'd0, b});
    e.r   = (b == 4'd0) ? 4'd0  : 4'(a % {4'd0, b});
    e.dbz = (b == 4'd0);
    sb.push_back(e);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    cyc    = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge Clk);
      cyc++;
      if (Done) seen = 1'b1;
      else if (Busy) busy_n++;
      if (glitch && (cyc == 3 || cyc == 5)) begin
        Start    = 1'b1;
        Dividend = 8'd255;
        Divisor  = 4'd0;
      end else begin
        Start = 1'b0;
      end
    end
    check({"done_seen ", id}, 32'(seen), 32'd1);
    check({"latency ", id}, 32'(cyc), (b == 4'd0) ? 32'd1 : 32'd9);
    check({"busy_cycles ", id}, 32'(busy_n), (b == 4'd0) ? 32'd0 : 32'd8);
    check({"busy_at_done ", id}, 32'(Busy), 32'd0);
    got = sb.pop_front();
    check({"quotient ", id}, 32'(Quotient), 32'(got.q));
    check({"remainder ", id}, 32'(Remainder), 32'(got.r));
    check({"divbyzero ", id}, 32'(DivByZero), 32'(got.dbz));
    check({"checkerr ", id}, 32'(CheckErr), 32'd0);
  endtask

  initial begin
    int done_n;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_quotient", 32'(Quotient), 32'd0);
    check("rst_remainder", 32'(Remainder), 32'd0);
    check("rst_divbyzero", 32'(DivByZero), 32'd0);
    check("rst_checkerr", 32'(CheckErr), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_op(8'd200, 4'd7, 1'b0);
    check("q_200_7", 32'(Quotient), 32'd28);
    check("r_200_7", 32'(Remainder), 32'd4);
    run_op(8'd255, 4'd15, 1'b0);
    run_op(8'd5, 4'd9, 1'b0);
    run_op(8'd0, 4'd1, 1'b0);
    run_op(8'd77, 4'd0, 1'b0);
    check("q_77_0", 32'(Quotient), 32'd255);
    run_op(8'd10, 4'd3, 1'b0);

    // Done is a single-cycle pulse while results hold.
    @(negedge Clk);
    check("done_pulse", 32'(Done), 32'd0);
    check("q_hold", 32'(Quotient), 32'd3);
    check("r_hold", 32'(Remainder), 32'd1);

    run_op(8'd100, 4'd6, 1'b1);
    check("q_100_6", 32'(Quotient), 32'd16);
    check("r_100_6", 32'(Remainder), 32'd4);

    // Reset in the middle of a run: abort with no Done.
    @(negedge Clk);
    Dividend = 8'd50;
    Divisor  = 4'd3;
    Start    = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (4) @(negedge Clk);
    check("busy_mid_run", 32'(Busy), 32'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("mrst_busy", 32'(Busy), 32'd0);
    check("mrst_done", 32'(Done), 32'd0);
    check("mrst_quotient", 32'(Quotient), 32'd0);
    check("mrst_remainder", 32'(Remainder), 32'd0);
    check("mrst_divbyzero", 32'(DivByZero), 32'd0);
    Reset_n = 1'b1;
    done_n  = 0;
    repeat (15) begin
      @(negedge Clk);
      if (Done || Busy) done_n++;
    end
    check("no_activity_after_reset", 32'(done_n), 32'd0);

    run_op(8'd9, 4'd2, 1'b0);

    // Exhaustive sweep, each Start issued in the previous operation's Done cycle.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
